lm_sm_sequencer: RTL and testbench

- Multi-cycle sequencer for the Load-Multiple (LM) and Store-Multiple (SM) instructions of the 16-bit RISC core.
- Sits directly upstream of Register_File:
  - drives the write port (RF_A3/RF_D3/RF_D3_EN) for LM;
  - drives read port 2 (RF_A2, consumes RF_D2) for SM.
- Walks an 8-bit register mask, issues one data-memory access per selected register, and holds the pipeline via busy until the transfer completes.

---
 rtl/lmsm_pkg.sv | 19 +
 rtl/lsb_priority_enc.sv | 30 +++
 rtl/lm_sm_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_lm_sm_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lmsm_pkg.sv
// Purpose: shared types and widths for the LM/SM sequencer slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lmsm_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 16;
    localparam int NREG_DEF   = 8;
    localparam int RIDX_W     = 3;    // register index width (R0..R7)

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCESS = 3'd1,
        ST_WRITE  = 3'd2,
        ST_BASEWB = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/lsb_priority_enc.sv
// Purpose: lowest-set-bit encoder over an NREG-bit register mask.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of mask.
//
// Ports:
//   mask  in   NREG   remaining register mask
//   idx   out  IDX_W  index of the lowest set bit (0 when mask is empty)
//   vld   out  1      mask has at least one bit set
module lsb_priority_enc #(
    parameter int NREG  = 8,
    parameter int IDX_W = 3
) (
    input  logic [NREG-1:0]  mask,
    output logic [IDX_W-1:0] idx,
    output logic             vld
);

    // Scan from the top down so the last hit, i.e. the lowest bit, wins.
    always_comb begin
        idx = '0;
        vld = 1'b0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = IDX_W'(i);
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lm_sm_sequencer.sv
// Purpose: walks an LM/SM register mask, one data-memory access per selected register.
// Latency: LM 2 cycles/register, SM 1 cycle/register, +1 DONE cycle (zero-wait memory).
// Backpressure: mem_ready low holds the current access with all memory outputs stable.
//
// Optional: define LMSM_BASE_WB_EN to add a BASEWB cycle that writes the final
// address pointer back to base_reg before DONE. Undefined, base_reg is ignored.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   start, is_store, reg_mask,      launch request and operands (latched in IDLE)
//   base_addr, base_reg
//   mem_addr/mem_re/mem_we/         data-memory request side
//   mem_wdata/mem_rdata/mem_ready
//   rf_a2/rf_d2                     register-file read port 2 (SM source)
//   rf_a3/rf_d3/rf_d3_en            register-file write port (LM destination)
//   busy, done                      pipeline stall and one-cycle completion pulse
module lm_sm_sequencer
    import lmsm_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int NREG      = NREG_DEF,
    parameter int ADDR_STEP = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              is_store,
    input  logic [NREG-1:0]   reg_mask,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [RIDX_W-1:0] base_reg,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [RIDX_W-1:0] rf_a2,
    input  logic [DATA_W-1:0] rf_d2,
    output logic [RIDX_W-1:0] rf_a3,
    output logic [DATA_W-1:0] rf_d3,
    output logic              rf_d3_en,
    output logic              busy,
    output logic              done
);

    state_t            state_q, state_d;
    logic [NREG-1:0]   mask_q, mask_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              st_q, st_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [RIDX_W-1:0] cur;
    logic              cur_vld;
    logic [NREG-1:0]   cur_bit;
    logic [NREG-1:0]   mask_rem;
    logic [ADDR_W-1:0] addr_inc;
    state_t            st_final;

`ifdef LMSM_BASE_WB_EN
    logic [RIDX_W-1:0] base_reg_q, base_reg_d;
    assign st_final = ST_BASEWB;
`else
    logic unused_base_reg;
    assign unused_base_reg = ^base_reg;
    assign st_final = ST_DONE;
`endif

    lsb_priority_enc #(
        .NREG  (NREG),
        .IDX_W (RIDX_W)
    ) u_enc (
        .mask (mask_q),
        .idx  (cur),
        .vld  (cur_vld)
    );

    // Mask left after retiring the current register; empty means last transfer.
    assign cur_bit  = cur_vld ? (NREG'(1) << cur) : '0;
    assign mask_rem = mask_q & ~cur_bit;
    // Address arithmetic wraps modulo 2^ADDR_W.
    assign addr_inc = addr_q + ADDR_W'(ADDR_STEP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            addr_q  <= '0;
            st_q    <= 1'b0;
            rdata_q <= '0;
`ifdef LMSM_BASE_WB_EN
            base_reg_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            addr_q  <= addr_d;
            st_q    <= st_d;
            rdata_q <= rdata_d;
`ifdef LMSM_BASE_WB_EN
            base_reg_q <= base_reg_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        addr_d    = addr_q;
        st_d      = st_q;
        rdata_d   = rdata_q;
`ifdef LMSM_BASE_WB_EN
        base_reg_d = base_reg_q;
`endif
        mem_addr  = '0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        rf_a2     = '0;
        rf_a3     = '0;
        rf_d3     = '0;
        rf_d3_en  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mask_d  = reg_mask;
                    addr_d  = base_addr;
                    st_d    = is_store;
`ifdef LMSM_BASE_WB_EN
                    base_reg_d = base_reg;
`endif
                    state_d = (reg_mask == '0) ? st_final : ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                busy     = 1'b1;
                mem_addr = addr_q;
                if (st_q) begin
                    // Store: register data flows straight through to memory.
                    mem_we    = 1'b1;
                    rf_a2     = cur;
                    mem_wdata = rf_d2;
                    if (mem_ready) begin
                        mask_d  = mask_rem;
                        addr_d  = addr_inc;
                        state_d = (mask_rem == '0) ? st_final : ST_ACCESS;
                    end
                end else begin
                    mem_re = 1'b1;
                    if (mem_ready) begin
                        rdata_d = mem_rdata;
                        state_d = ST_WRITE;
                    end
                end
            end

            ST_WRITE: begin
                busy     = 1'b1;
                rf_a3    = cur;
                rf_d3    = rdata_q;
                rf_d3_en = 1'b1;
                mask_d   = mask_rem;
                addr_d   = addr_inc;
                state_d  = (mask_rem == '0) ? st_final : ST_ACCESS;
            end

            ST_BASEWB: begin
                busy = 1'b1;
`ifdef LMSM_BASE_WB_EN
                // Final pointer overrides any value an LM loaded into base_reg.
                rf_a3    = base_reg_q;
                rf_d3    = DATA_W'(addr_q);
                rf_d3_en = 1'b1;
`endif
                state_d = ST_DONE;
            end

            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Purpose: self-checking bench for lm_sm_sequencer against a per-transfer schedule model.
// Latency: n/a.
// Backpressure: memory waits injected per register from the model's schedule.
module tb_lm_sm_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [7:0]  reg_mask = '0;
    logic [15:0] base_addr = '0;
    logic [2:0]  base_reg = '0;
    logic [15:0] mem_addr;
    logic        mem_re, mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic [2:0]  rf_a2, rf_a3;
    logic [15:0] rf_d2, rf_d3;
    logic        rf_d3_en, busy, done;

    always #5 clk = ~clk;

    lm_sm_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store),
        .reg_mask(reg_mask), .base_addr(base_addr), .base_reg(base_reg),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .rf_a2(rf_a2), .rf_d2(rf_d2), .rf_a3(rf_a3), .rf_d3(rf_d3),
        .rf_d3_en(rf_d3_en), .busy(busy), .done(done)
    );

    // Register file seen by the DUT.
    logic [15:0] rf [8];
    logic [15:0] init_vals [8];
    logic        init_req = 1'b0;
    assign rf_d2 = rf[rf_a2];
    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < 8; i++) rf[i] <= init_vals[i];
        end else if (rf_d3_en) begin
            rf[rf_a3] <= rf_d3;
        end
    end

    // One expected output cycle, plus the memory response to drive in it.
    typedef struct {
        logic        busy, done, re, we, d3en, ready;
        logic [15:0] addr, wdata, d3, rdata;
        logic [2:0]  a2, a3;
    } cyc_t;

    cyc_t        exp_q[$];
    cyc_t        exp_cur;
    logic        chk_en = 1'b0;
    logic [15:0] model_regs [8];
    int          waits [8];
    logic [15:0] ld_data [8];
    int          n_vec = 0;
    int          n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic cyc_t idle_cyc();
        cyc_t r;
        r.busy = 0; r.done = 0; r.re = 0; r.we = 0; r.d3en = 0;
        r.ready = 1'($urandom_range(0, 1));
        r.addr = 0; r.wdata = 0; r.d3 = 0; r.rdata = 16'($urandom);
        r.a2 = 0; r.a3 = 0;
        return r;
    endfunction

    // Schedule model: registers ascend, each access waits waits[i] cycles then
    // completes; LM spends one extra cycle writing the loaded word; a single
    // DONE cycle follows. Addresses step by one and wrap at 16 bits.
    function automatic void build(input logic st, input logic [7:0] m, input logic [15:0] base);
        cyc_t r;
        logic [15:0] a;
        a = base;
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
                for (int w = 0; w <= waits[i]; w++) begin
                    r = idle_cyc();
                    r.busy = 1; r.addr = a;
                    r.ready = (w == waits[i]);
                    if (st) begin
                        r.we = 1; r.a2 = 3'(i); r.wdata = model_regs[i];
                    end else begin
                        r.re = 1;
                        if (w == waits[i]) r.rdata = ld_data[i];
                    end
                    exp_q.push_back(r);
                end
                if (!st) begin
                    r = idle_cyc();
                    r.busy = 1; r.d3en = 1; r.a3 = 3'(i); r.d3 = ld_data[i];
                    exp_q.push_back(r);
                    model_regs[i] = ld_data[i];
                end
                a = a + 16'd1;
            end
        end
        r = idle_cyc();
        r.done = 1;
        exp_q.push_back(r);
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",      32'(busy),      32'(exp_cur.busy));
            chk("done",      32'(done),      32'(exp_cur.done));
            chk("mem_re",    32'(mem_re),    32'(exp_cur.re));
            chk("mem_we",    32'(mem_we),    32'(exp_cur.we));
            chk("mem_addr",  32'(mem_addr),  32'(exp_cur.addr));
            chk("mem_wdata", 32'(mem_wdata), 32'(exp_cur.wdata));
            chk("rf_a2",     32'(rf_a2),     32'(exp_cur.a2));
            chk("rf_a3",     32'(rf_a3),     32'(exp_cur.a3));
            chk("rf_d3",     32'(rf_d3),     32'(exp_cur.d3));
            chk("rf_d3_en",  32'(rf_d3_en),  32'(exp_cur.d3en));
        end
    end

    task automatic load_rf();
        for (int i = 0; i < 8; i++) init_vals[i] = model_regs[i];
        @(posedge clk); #1;
        init_req = 1'b1;
        @(posedge clk); #1;
        init_req = 1'b0;
    endtask

    task automatic clear_waits();
        for (int i = 0; i < 8; i++) begin
            waits[i] = 0;
            ld_data[i] = 16'($urandom);
        end
    endtask

    // Applies exp_q after a start cycle. noise drives random ignored starts
    // while busy and in DONE. stop_at>=0 aborts with reset during that record.
    task automatic apply(input logic st, input logic [7:0] m, input logic [15:0] base,
                         input bit noise, input int stop_at);
        @(posedge clk); #1;
        start = 1; is_store = st; reg_mask = m; base_addr = base;
        base_reg = 3'($urandom);
        exp_cur = idle_cyc(); mem_ready = exp_cur.ready; chk_en = 1;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(posedge clk); #1;
            exp_cur = exp_q[k];
            mem_ready = exp_q[k].ready; mem_rdata = exp_q[k].rdata;
            if (noise) begin
                start = 1'($urandom); is_store = 1'($urandom);
                reg_mask = 8'($urandom); base_addr = 16'($urandom);
            end else begin
                start = 0;
            end
            if (k == stop_at) begin
                @(negedge clk); #1;
                chk_en = 0; start = 0; rst_n = 0;
                #1;
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_d3en", 32'(rf_d3_en), 32'd0);
                chk("abort_re",   32'(mem_re), 32'd0);
                chk("abort_done", 32'(done), 32'd0);
                exp_cur = idle_cyc(); chk_en = 1;
                @(posedge clk); @(posedge clk);
                @(negedge clk); #1;
                rst_n = 1;
                return;
            end
        end
        @(posedge clk); #1;
        start = 0; exp_cur = idle_cyc(); mem_ready = exp_cur.ready;
    endtask

    initial begin
        logic [15:0] snap [8];
        for (int i = 0; i < 8; i++) model_regs[i] = 16'($urandom);
        clear_waits();
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_strb", 32'({mem_re, mem_we, rf_d3_en}), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        #10;
        rst_n = 1;
        load_rf();

        // LM R1,R2 from 0x0040.
        clear_waits();
        ld_data[1] = 16'hAAAA; ld_data[2] = 16'h5555;
        build(1'b0, 8'b0000_0110, 16'h0040);
        chk("lm_len",   32'(exp_q.size()), 32'd5);
        chk("lm_addr0", 32'(exp_q[0].addr), 32'h0040);
        chk("lm_addr1", 32'(exp_q[2].addr), 32'h0041);
        chk("lm_d3_1",  32'(exp_q[3].d3), 32'h5555);
        apply(1'b0, 8'b0000_0110, 16'h0040, 1'b1, -1);
        chk("lm_r1", 32'(rf[1]), 32'hAAAA);
        chk("lm_r2", 32'(rf[2]), 32'h5555);

        // SM R0,R7 to 0x0100.
        model_regs[0] = 16'h0012; model_regs[7] = 16'hBEEF;
        load_rf();
        clear_waits();
        build(1'b1, 8'b1000_0001, 16'h0100);
        chk("sm_w0", 32'(exp_q[0].wdata), 32'h0012);
        chk("sm_w1", 32'(exp_q[1].wdata), 32'hBEEF);
        chk("sm_a1", 32'(exp_q[1].addr), 32'h0101);
        apply(1'b1, 8'b1000_0001, 16'h0100, 1'b0, -1);

        // SM all registers across the address wrap, third access stalls 2 cycles.
        clear_waits();
        waits[2] = 2;
        build(1'b1, 8'hFF, 16'hFFFE);
        chk("wrap_a2", 32'(exp_q[4].addr), 32'h0000);
        chk("wrap_last", 32'(exp_q[9].addr), 32'h0005);
        apply(1'b1, 8'hFF, 16'hFFFE, 1'b1, -1);

        // Empty mask: DONE straight away.
        build(1'b0, 8'h00, 16'h1234);
        chk("empty_len", 32'(exp_q.size()), 32'd1);
        apply(1'b0, 8'h00, 16'h1234, 1'b0, -1);

        // Reset during the second WRITE of a 4-register LM.
        clear_waits();
        for (int i = 0; i < 8; i++) snap[i] = model_regs[i];
        build(1'b0, 8'h0F, 16'h0300);
        apply(1'b0, 8'h0F, 16'h0300, 1'b0, 3);
        for (int i = 0; i < 8; i++) model_regs[i] = snap[i];
        for (int k = 0; k < 3; k++)
            if (exp_q[k].d3en) model_regs[exp_q[k].a3] = exp_q[k].d3;
        clear_waits();
        build(1'b0, 8'h0F, 16'h0300);
        apply(1'b0, 8'h0F, 16'h0300, 1'b0, -1);

        // Randomized operations.
        for (int t = 0; t < 40; t++) begin
            logic        st;
            logic [7:0]  m;
            logic [15:0] b;
            st = 1'($urandom);
            m = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            b = ($urandom_range(0, 3) == 0) ? 16'hFFFC : 16'($urandom);
            for (int i = 0; i < 8; i++) begin
                waits[i] = $urandom_range(0, 2);
                ld_data[i] = 16'($urandom);
            end
            build(st, m, b);
            apply(st, m, b, 1'($urandom), -1);
        end

        @(posedge clk); #1;
        chk_en = 0;
        for (int i = 0; i < 8; i++) chk("rf_final", 32'(rf[i]), 32'(model_regs[i]));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
